adc_responder: RTL and testbench

ADC_RESPONDER -- requirements
Module: adc_responder

---
 rtl/adc_responder.sv | 174 +++++++++++++++++
 tb/tb_adc_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// adc_responder: serial-ADC slave emulator.
// A master selects a channel over sclk/cs/din with a start bit followed by
// SGL, D2, D1 and D0. The block answers with a null bit and then a 12-bit
// conversion value, MSB first. Single-ended mode returns the selected channel.
// Differential mode returns the pair difference, saturated at zero.
// Ports:
//   clk, rst        system clock (>= 8x sclk) and async active-low reset
//   sclk, cs, din   master serial interface (async to clk, cs active-low)
//   ch_data         eight 12-bit channel values, channel n at [12n+11:12n]
//   dout, dout_oe   serial response and its drive enable
//   conv_done       one-clk pulse after the last data bit is driven
//   conv_ch         channel field of the last accepted command
//   conv_single     SGL/DIFF bit of the last accepted command
//   frame_abort     one-clk pulse when cs rises mid-frame
module adc_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        din,
  input  logic [95:0] ch_data,
  output logic        dout,
  output logic        dout_oe,
  output logic        conv_done,
  output logic [2:0]  conv_ch,
  output logic        conv_single,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, CMD, SAMPLE, NULLB, DATA, TAIL
  } state_t;

  state_t      state;
  logic [1:0]  sclk_sync, cs_sync, din_sync;
  logic        sclk_prev, cs_prev;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
  logic [3:0]  cnt;
  logic [3:0]  cmd;       // {SGL, D2, D1, D0}
  logic [11:0] shreg;

  // Synchronizers plus one history flop per line for edge detection.
  // cs history is preset high so reset release alone cannot look like a cs edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      din_sync  <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      din_sync  <= {din_sync[0], din};
      cs_sync   <= {cs_sync[0], cs};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_rise   = cs_sync[1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[1] & cs_prev;
  assign din_s     = din_sync[1];

  // Conversion value for the command currently held in cmd.
  logic [11:0] ch [8];
  logic [11:0] op_a, op_b, conv_value;
  logic [12:0] diff;

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      ch[i] = ch_data[12*i +: 12];
    end
    // D0 selects the subtraction direction within pair {D2,D1}.
    op_a = cmd[0] ? ch[{cmd[2:1], 1'b1}] : ch[{cmd[2:1], 1'b0}];
    op_b = cmd[0] ? ch[{cmd[2:1], 1'b0}] : ch[{cmd[2:1], 1'b1}];
    diff = {1'b0, op_a} - {1'b0, op_b};
    if (cmd[3]) begin
      conv_value = ch[cmd[2:0]];
    end else begin
      // A borrow out of the 13-bit subtract means negative: clamp to zero.
      conv_value = diff[12] ? '0 : diff[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd         <= '0;
      shreg       <= '0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_done   <= 1'b0;
      frame_abort <= 1'b0;
      conv_ch     <= '0;
      conv_single <= 1'b0;
    end else begin
      conv_done   <= 1'b0;
      frame_abort <= 1'b0;
      if (cs_rise) begin
        // cs rise wins over any sclk edge seen in the same clk.
        if (state inside {CMD, SAMPLE, NULLB, DATA}) begin
          frame_abort <= 1'b1;
        end
        state   <= IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dout    <= 1'b0;
            dout_oe <= 1'b0;
            if (cs_fall) begin
              state <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (sclk_rise && din_s) begin
              cnt   <= '0;
              state <= CMD;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd <= {cmd[2:0], din_s};
              cnt <= cnt + 4'd1;
              if (cnt == 4'd3) begin
                state <= SAMPLE;
              end
            end
          end
          SAMPLE: begin
            if (sclk_rise) begin
              shreg       <= conv_value;
              conv_single <= cmd[3];
              conv_ch     <= cmd[2:0];
              state       <= NULLB;
            end
          end
          NULLB: begin
            if (sclk_fall) begin
              dout_oe <= 1'b1;
              dout    <= 1'b0;
              cnt     <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (sclk_fall) begin
              dout  <= shreg[11];
              shreg <= {shreg[10:0], 1'b0};
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd11) begin
                conv_done <= 1'b1;
                state     <= TAIL;
              end
            end
          end
          TAIL: begin
            // B0 stays on dout until the next fall, then the line idles low.
            dout_oe <= 1'b1;
            if (sclk_fall) begin
              dout <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed and randomized frames for adc_responder,
// checked against a behavioural model of the conversion rules.
module tb_adc_responder;

  localparam int T    = 10;   // clk period
  localparam int HALF = 50;   // sclk half period (sclk = clk / 10)

  logic        clk = 1'b0;
  logic        rst, sclk, cs, din;
  logic [95:0] ch_data;
  logic        dout, dout_oe, conv_done, conv_single, frame_abort;
  logic [2:0]  conv_ch;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  adc_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .din(din), .ch_data(ch_data),
    .dout(dout), .dout_oe(dout_oe), .conv_done(conv_done), .conv_ch(conv_ch),
    .conv_single(conv_single), .frame_abort(frame_abort)
  );

  always #(T/2) clk = ~clk;

  // Pulses are counted on the falling clk edge, away from the update edge.
  always @(negedge clk) begin
    if (conv_done)   done_cnt  = done_cnt + 1;
    if (frame_abort) abort_cnt = abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [95:0] d, input logic [3:0] c);
    int a, b, r;
    int unsigned p;
    if (c[3]) return d[int'(c[2:0]) * 12 +: 12];
    p = int'(c[2:1]);
    a = int'(d[p * 24 +: 12]);
    b = int'(d[p * 24 + 12 +: 12]);
    r = c[0] ? b - a : a - b;
    if (r < 0) r = 0;
    return 12'(r);
  endfunction

  // mode 0: full frame; 1: cs raised after stop_at data bits;
  // 2: reset pulsed after stop_at data bits; 3: ch_data scrambled after stop_at bits.
  task automatic run_frame(input logic [3:0] c, input int unsigned zeros,
                           input int unsigned mode, input int unsigned stop_at);
    logic        bits [$];
    logic [11:0] exp, got;
    int unsigned total, ndata;
    int          d0, a0;
    exp = model(ch_data, c);
    d0 = done_cnt;
    a0 = abort_cnt;
    bits = {};
    repeat (zeros) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = 3; i >= 0; i--) bits.push_back(c[i]);
    total = zeros + 19;
    got = '0;
    ndata = 0;
    cs = 1'b0;
    #(HALF);
    for (int unsigned r = 1; r <= total; r++) begin
      din = (r <= bits.size()) ? bits[r-1] : 1'b0;
      #(HALF);
      if (r == zeros + 7) begin
        check("null_oe", dout_oe, 1);
        check("null_bit", dout, 0);
      end else if (r > zeros + 7) begin
        got = {got[10:0], dout};
        ndata++;
      end
      if (mode == 3 && ndata == stop_at && r > zeros + 7)
        ch_data = {$urandom, $urandom, $urandom};
      if ((mode == 1 || mode == 2) && ndata == stop_at) break;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    if (mode == 0 || mode == 3) begin
      #(HALF);
      check("tail_dout", dout, 0);
      check("tail_oe", dout_oe, 1);
      check("data", got, exp);
      cs = 1'b1;
      #(4*T);
      check("end_oe", dout_oe, 0);
      check("done_pulses", done_cnt - d0, 1);
      check("abort_none", abort_cnt - a0, 0);
      check("conv_ch", conv_ch, c[2:0]);
      check("conv_single", conv_single, c[3]);
    end else if (mode == 1) begin
      cs = 1'b1;
      #(4*T);
      check("abort_oe", dout_oe, 0);
      check("abort_dout", dout, 0);
      check("abort_bits", got, exp >> (12 - stop_at));
      #(2*T);
      check("abort_pulses", abort_cnt - a0, 1);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_ch_held", conv_ch, c[2:0]);
      check("abort_sgl_held", conv_single, c[3]);
    end else begin
      rst = 1'b0;
      #(2*T);
      check("rst_outs", {dout, dout_oe, conv_done, frame_abort, conv_single, conv_ch}, 0);
      rst = 1'b1;
      #(2*T);
      cs = 1'b1;
      #(4*T);
      check("rst_oe", dout_oe, 0);
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_no_abort", abort_cnt - a0, 0);
    end
    #(2*HALF);
  endtask

  initial begin
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; din = 1'b0; ch_data = '0;
    #(2*T);
    check("reset_outs", {dout, dout_oe, conv_done, frame_abort, conv_single, conv_ch}, 0);
    #(3*T);
    rst = 1'b1;
    #(2*HALF);

    // Single read of channel 3.
    ch_data[3*12 +: 12] = 12'hA5C;
    run_frame(4'b1011, 0, 0, 0);

    // Differential pair 2 (ch4, ch5): saturating and positive directions.
    ch_data[4*12 +: 12] = 12'd100;
    ch_data[5*12 +: 12] = 12'd300;
    run_frame(4'b0100, 0, 0, 0);
    run_frame(4'b0101, 0, 0, 0);

    // Leading zeros before the start bit.
    ch_data[7*12 +: 12] = 12'hFFF;
    run_frame(4'b1111, 3, 0, 0);

    // Abort after 5 data bits, then a clean read of channel 0.
    ch_data[2*12 +: 12] = 12'h9B3;
    run_frame(4'b1010, 1, 1, 5);
    ch_data[0 +: 12] = 12'h001;
    run_frame(4'b1000, 0, 0, 0);

    // ch_data changes mid-DATA must not disturb the shifted value.
    ch_data = {$urandom, $urandom, $urandom};
    run_frame(4'b1110, 0, 3, 4);

    // Reset mid-DATA, then a normal frame.
    ch_data = {$urandom, $urandom, $urandom};
    run_frame(4'b0011, 0, 2, 6);
    check("post_rst_ch", conv_ch, 0);
    ch_data = {$urandom, $urandom, $urandom};
    run_frame(4'b0110, 1, 0, 0);

    // Randomized frames.
    for (int k = 0; k < 20; k++) begin
      ch_data = {$urandom, $urandom, $urandom};
      run_frame(4'($urandom), $urandom_range(0, 3), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
